// File: rtl/serial_demux_pkg.sv
// Shared types and constants for the serial frame demultiplexer.
// The optional parity beat is enabled by defining SERIAL_DEMUX_PARITY_EN.
package serial_demux_pkg;

   localparam int DEMUX_MAX_CH = 8;
   localparam int DEMUX_SEL_W  = $clog2(DEMUX_MAX_CH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      PARITY   = 2'd2,
      WAIT_OUT = 2'd3
   } demux_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry ready/valid holding register for the reassembled word.
// Carries a parity error flag alongside the word when SERIAL_DEMUX_PARITY_EN is defined.
module demux_out_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] word_i,
`ifdef SERIAL_DEMUX_PARITY_EN
   input  logic         perr_i,
   output logic         perr_o,
`endif
   input  logic         ready_i,
   output logic [W-1:0] dout_o,
   output logic         valid_o
);

   logic [W-1:0] dout_q, dout_d;
   logic         valid_q, valid_d;
`ifdef SERIAL_DEMUX_PARITY_EN
   logic         perr_q, perr_d;
`endif

   // A load in the handshake cycle replaces the word without a bubble.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
`ifdef SERIAL_DEMUX_PARITY_EN
      perr_d  = perr_q;
`endif
      if (load_i) begin
         dout_d  = word_i;
         valid_d = 1'b1;
`ifdef SERIAL_DEMUX_PARITY_EN
         perr_d  = perr_i;
`endif
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
`ifdef SERIAL_DEMUX_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign dout_o  = dout_q;
   assign valid_o = valid_q;
`ifdef SERIAL_DEMUX_PARITY_EN
   assign perr_o  = perr_q;
`endif

endmodule

// File: rtl/serial_frame_demux.sv
// Drives the mux select, collects one bit per channel and emits the parallel word.
// Defining SERIAL_DEMUX_PARITY_EN adds a trailing even-parity beat and the parity_err port.
module serial_frame_demux
   import serial_demux_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              din,
   input  logic              din_valid,
   output logic              x,
   output logic              y,
   output logic              z,
   output logic              busy,
   output logic [NUM_CH-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready
`ifdef SERIAL_DEMUX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

   demux_state_t      state_q, state_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [NUM_CH-1:0] shadow_q, shadow_d;
   logic              load;
   logic              slot_free;
`ifdef SERIAL_DEMUX_PARITY_EN
   logic              perr_q, perr_d;
`endif

   assign slot_free = !dout_valid || dout_ready;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      load     = 1'b0;
`ifdef SERIAL_DEMUX_PARITY_EN
      perr_d   = perr_q;
`endif
      unique case (state_q)
         IDLE: begin
            idx_d    = '0;
            shadow_d = '0;
            if (start) state_d = COLLECT;
         end
         COLLECT: begin
            if (din_valid) begin
               shadow_d[idx_q] = din;
               if (idx_q == LAST_IDX) begin
`ifdef SERIAL_DEMUX_PARITY_EN
                  state_d = PARITY;
`else
                  if (slot_free) begin
                     load    = 1'b1;
                     idx_d   = '0;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT_OUT;
                  end
`endif
               end else begin
                  idx_d = idx_q + SEL_W'(1);
               end
            end
         end
`ifdef SERIAL_DEMUX_PARITY_EN
         PARITY: begin
            if (din_valid) begin
               perr_d = ^{shadow_q, din};
               if (slot_free) begin
                  load    = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_OUT;
               end
            end
         end
`endif
         WAIT_OUT: begin
            // Select stays on the last channel until the word leaves.
            if (slot_free) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
`ifdef SERIAL_DEMUX_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
`ifdef SERIAL_DEMUX_PARITY_EN
         perr_q   <= perr_d;
`endif
      end
   end

   assign {x, y, z} = DEMUX_SEL_W'(idx_q);
   assign busy      = (state_q != IDLE);

   demux_out_slot #(
      .W (NUM_CH)
   ) u_out_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .word_i  (shadow_d),
`ifdef SERIAL_DEMUX_PARITY_EN
      .perr_i  (perr_d),
      .perr_o  (parity_err),
`endif
      .ready_i (dout_ready),
      .dout_o  (dout),
      .valid_o (dout_valid)
   );

endmodule

// File: tb/tb_serial_frame_demux.sv
// Self-checking bench for serial_frame_demux; expected words come from a queue-based frame model.
// Parity scenarios are exercised when SERIAL_DEMUX_PARITY_EN is defined.
module tb_serial_frame_demux;

   localparam int NUM_CH = 8;
`ifdef SERIAL_DEMUX_PARITY_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              din;
   logic              din_valid;
   logic              x, y, z;
   logic              busy;
   logic [NUM_CH-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
`ifdef SERIAL_DEMUX_PARITY_EN
   logic              parity_err;
`endif

   typedef struct {
      logic [NUM_CH-1:0] word;
      logic              perr;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   failures  = 0;
   bit   rnd_ready = 1'b0;
   int   lat;

   always #5 clk = ~clk;

   serial_frame_demux #(
      .NUM_CH (NUM_CH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .x          (x),
      .y          (y),
      .z          (z),
      .busy       (busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef SERIAL_DEMUX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int sel();
      return int'({x, y, z});
   endfunction

   // One clock; the consumer side of the model is checked just before each edge.
   task automatic step();
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
      if (dout_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(dout_valid), 32'd0);
         end else begin
            check("dout", 32'(dout), 32'(exp_q[0].word));
`ifdef SERIAL_DEMUX_PARITY_EN
            check("parity_err", 32'(parity_err), 32'(exp_q[0].perr));
`endif
            if (dout_ready) void'(exp_q.pop_front());
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 100 && busy; n++) step();
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   // gap_mode: 0 continuous, 1 alternate low/high, 2 random.
   task automatic send_frame(input logic [NUM_CH-1:0] w, input int gap_mode,
                             input logic pbit, input int start_at, output int latency);
      int   tries;
      int   ch;
      logic bitv;
      logic v;
      wait_idle();
      start = 1'b1;
      step();
      start = 1'b0;
      latency = 1;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < NUM_CH + EXTRA; i++) begin
         ch    = (i < NUM_CH) ? i : NUM_CH - 1;
         bitv  = (i < NUM_CH) ? w[i] : pbit;
         tries = 0;
         do begin
            check("select", 32'(sel()), 32'(ch));
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = (tries % 2 == 1);
               default: v = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            din_valid = v;
            din       = v ? bitv : ~bitv;
            start     = (i == start_at && tries == 0);
            step();
            start     = 1'b0;
            latency++;
            tries++;
         end while (!v);
      end
      din_valid = 1'b0;
      exp_q.push_back('{word: w, perr: (^w) ^ pbit});
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      din        = 1'b0;
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sel", 32'(sel()), 32'd0);
      check("rst_dout_valid", 32'(dout_valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
`ifdef SERIAL_DEMUX_PARITY_EN
      check("rst_parity_err", 32'(parity_err), 32'd0);
`endif
      rst = 1'b0;
      step();

      // Continuous beats: word appears NUM_CH+1 (+1 with parity) cycles after start.
      send_frame(8'h96, 0, 1'b0, -1, lat);
      check("t1_valid", 32'(dout_valid), 32'd1);
      check("t1_latency", 32'(lat), 32'(NUM_CH + 1 + EXTRA));
      check("t1_dout", 32'(dout), 32'h96);
      check("t1_idle", 32'(busy), 32'd0);
      step();
      check("t1_one_cycle", 32'(dout_valid), 32'd0);

      // Alternate-cycle gaps.
      send_frame(8'h96, 1, 1'b0, -1, lat);
      check("t2_valid", 32'(dout_valid), 32'd1);
      check("t2_dout", 32'(dout), 32'h96);
      step();

      // Back-pressure: second frame parks in WAIT_OUT.
      dout_ready = 1'b0;
      send_frame(8'h96, 0, 1'b0, -1, lat);
      check("t3_first_valid", 32'(dout_valid), 32'd1);
      send_frame(8'h5A, 0, 1'b0, -1, lat);
      check("t3_wait_busy", 32'(busy), 32'd1);
      check("t3_wait_sel", 32'(sel()), 32'(NUM_CH - 1));
      repeat (3) step();
      check("t3_held", 32'(dout), 32'h96);
      check("t3_still_busy", 32'(busy), 32'd1);
      dout_ready = 1'b1;
      step();
      check("t3_second", 32'(dout), 32'h5A);
      check("t3_second_valid", 32'(dout_valid), 32'd1);
      check("t3_released", 32'(busy), 32'd0);
      step();
      check("t3_drained", 32'(dout_valid), 32'd0);

      // Reset mid-frame while an unconsumed word sits in the slot.
      dout_ready = 1'b0;
      send_frame(8'h3C, 0, 1'b0, -1, lat);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t4_start_while_valid", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din       = 1'b1;
         step();
      end
      check("t4_mid_sel", 32'(sel()), 32'd4);
      din_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_sel", 32'(sel()), 32'd0);
      check("t4_dout_valid", 32'(dout_valid), 32'd0);
      check("t4_dout", 32'(dout), 32'd0);
      dout_ready = 1'b1;
      send_frame(8'hFF, 0, 1'b0, -1, lat);
      check("t4_full", 32'(dout), 32'hFF);
      step();

      // start during COLLECT must not restart the index.
      send_frame(8'hA5, 0, 1'b0, 3, lat);
      check("t5_latency", 32'(lat), 32'(NUM_CH + 1 + EXTRA));
      check("t5_dout", 32'(dout), 32'hA5);
      step();

      // rst wins over a simultaneous start.
      rst   = 1'b1;
      start = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      check("t6_rst_wins", 32'(busy), 32'd0);
      step();
      check("t6_still_idle", 32'(busy), 32'd0);

`ifdef SERIAL_DEMUX_PARITY_EN
      send_frame(8'h96, 0, 1'b0, -1, lat);
      check("t7_perr0", 32'(parity_err), 32'd0);
      check("t7_word0", 32'(dout), 32'h96);
      step();
      send_frame(8'h96, 0, 1'b1, -1, lat);
      check("t7_perr1", 32'(parity_err), 32'd1);
      check("t7_word1", 32'(dout), 32'h96);
      step();
`endif

      // Random words, gaps and consumer stalls.
      rnd_ready = 1'b1;
      for (int f = 0; f < 24; f++) begin
         send_frame(NUM_CH'($urandom), 2, 1'($urandom_range(0, 1)), -1, lat);
      end
      rnd_ready  = 1'b0;
      dout_ready = 1'b1;
      for (int n = 0; n < 40 && (exp_q.size() != 0 || dout_valid || busy); n++) step();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_valid_low", 32'(dout_valid), 32'd0);
      check("final_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
